// File: rtl/memory_to_write_back_pipe_if.sv
// MEM->WB pipeline handshake and payload bundle; the slave modport is the
// pipe's own view, the master modport is the surrounding stages' view.
interface memory_to_write_back_pipe_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5
);

  logic                     i_ValidM;
  logic                     o_ReadyM;
  logic [DATA_WIDTH-1:0]    i_ALUOutM;
  logic [DATA_WIDTH-1:0]    i_ReadDataM;
  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM;
  logic [ADDRESS_WIDTH-1:0] i_PCPlus4M;
  logic                     i_RegWriteM;
  logic [1:0]               i_MemtoRegM;
  logic                     i_FlushW;
  logic                     o_ValidW;
  logic                     i_ReadyW;
  logic [DATA_WIDTH-1:0]    o_ALUOutW;
  logic [DATA_WIDTH-1:0]    o_ReadDataW;
  logic [RF_ADDR_WIDTH-1:0] o_WriteRegW;
  logic [ADDRESS_WIDTH-1:0] o_PCPlus4W;
  logic                     o_RegWriteW;
  logic [1:0]               o_MemtoRegW;
  logic [1:0]               o_Occupancy;

  modport slave (
    input  i_ValidM, i_ALUOutM, i_ReadDataM, i_WriteRegM, i_PCPlus4M, i_RegWriteM,
    input  i_MemtoRegM, i_FlushW, i_ReadyW,
    output o_ReadyM, o_ValidW, o_ALUOutW, o_ReadDataW, o_WriteRegW, o_PCPlus4W,
    output o_RegWriteW, o_MemtoRegW, o_Occupancy
  );

  modport master (
    output i_ValidM, i_ALUOutM, i_ReadDataM, i_WriteRegM, i_PCPlus4M, i_RegWriteM,
    output i_MemtoRegM, i_FlushW, i_ReadyW,
    input  o_ReadyM, o_ValidW, o_ALUOutW, o_ReadDataW, o_WriteRegW, o_PCPlus4W,
    input  o_RegWriteW, o_MemtoRegW, o_Occupancy
  );

endinterface

// File: rtl/memory_to_write_back_pipe.sv
// MEM->WB pipeline register with valid/ready handshake and flush.
// Define MEM_WB_SKID_BUFFER_EN for a 2-entry skid buffer with a registered o_ReadyM.
module memory_to_write_back_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned RF_ADDR_WIDTH = 5
) (
  input logic                        i_CLK,
  input logic                        i_RST,
  memory_to_write_back_pipe_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    alu_out;
    logic [DATA_WIDTH-1:0]    read_data;
    logic [RF_ADDR_WIDTH-1:0] write_reg;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic                     reg_write;
    logic [1:0]               mem_to_reg;
  } beat_t;

  // State counts held beats; StTwo is only reachable with the skid entry.
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  beat_t  in_beat;
  beat_t  main_q;
  logic   ready;
  logic   valid_w;
  logic   accept;
  logic   deliver;
  logic   flush;
  logic   load_main_in;

  assign flush   = bus.i_FlushW;
  assign accept  = bus.i_ValidM & ready;
  assign deliver = valid_w & bus.i_ReadyW;

  // Writes to $zero are squashed at capture time.
  always_comb begin
    in_beat            = '0;
    in_beat.alu_out    = bus.i_ALUOutM;
    in_beat.read_data  = bus.i_ReadDataM;
    in_beat.write_reg  = bus.i_WriteRegM;
    in_beat.pc_plus4   = bus.i_PCPlus4M;
    in_beat.reg_write  = bus.i_RegWriteM & (bus.i_WriteRegM != '0);
    in_beat.mem_to_reg = bus.i_MemtoRegM;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (deliver && !accept) begin
            state_d = StEmpty;
          end else if (accept && !deliver) begin
            state_d = StTwo;
          end
        end
        StTwo:   if (deliver) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    load_main_in = accept && !flush &&
                   ((state_q == StEmpty) || ((state_q == StOne) && deliver));
  end

`ifdef MEM_WB_SKID_BUFFER_EN
  beat_t skid_q;
  logic  ready_q;
  logic  load_skid;
  logic  load_main_skid;

  always_comb begin
    load_skid      = accept && !flush && (state_q == StOne) && !deliver;
    load_main_skid = deliver && !flush && (state_q == StTwo);
  end

  // Ready is registered from next-state so WB backpressure never reaches o_ReadyM
  // combinationally; it resets high so the first edge after reset can accept.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != StTwo);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_beat;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_beat;
      end
    end
  end
`else
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_beat;
    end
  end
`endif

  // Payload is driven straight from the main entry so it holds while stalled or empty.
  always_comb begin
    valid_w = (state_q != StEmpty);
`ifdef MEM_WB_SKID_BUFFER_EN
    ready           = ready_q;
    bus.o_Occupancy = {state_q == StTwo, state_q == StOne};
`else
    ready           = ~valid_w | bus.i_ReadyW;
    bus.o_Occupancy = {1'b0, state_q == StOne};
`endif
    bus.o_ReadyM    = ready;
    bus.o_ValidW    = valid_w;
    bus.o_ALUOutW   = main_q.alu_out;
    bus.o_ReadDataW = main_q.read_data;
    bus.o_WriteRegW = main_q.write_reg;
    bus.o_PCPlus4W  = main_q.pc_plus4;
    bus.o_RegWriteW = main_q.reg_write & valid_w;
    bus.o_MemtoRegW = main_q.mem_to_reg;
  end

endmodule
